// File: rtl/pipo_shift_ctrl.sv
// Sequencer for an 8-bit load/shift-left pipo register: load a nibble, shift it N times, return Q.
// Optional capture-time self-check of pipo_q enabled by defining PIPO_SHIFT_CTRL_CHECK_EN.
`timescale 1ns/1ps

module pipo_shift_ctrl #(
   parameter int SHAMT_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_nibble,
   input  logic [SHAMT_W-1:0] in_shamt,
   output logic [3:0]         pipo_d,
   output logic               pipo_sel,
   input  logic [7:0]         pipo_q,
   output logic               result_valid,
   input  logic               result_ready,
   output logic [7:0]         result,
   output logic               busy,
   output logic               err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_CAPTURE,
      S_RESP
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [3:0]           r_nibble;
   logic [SHAMT_W-1:0]   r_shamt;
   logic [SHAMT_W-1:0]   r_cnt;
   logic [7:0]           r_result;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (in_valid) w_next = S_LOAD;
         S_LOAD:    w_next = (r_shamt != '0) ? S_SHIFT : S_CAPTURE;
         S_SHIFT:   if (r_cnt == SHAMT_W'(1)) w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_RESP;
         S_RESP:    if (result_ready) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Pipo outputs are pure decodes of the registered state, so they settle right after the edge.
   always_comb begin
      in_ready     = 1'b0;
      busy         = 1'b1;
      pipo_sel     = 1'b0;
      pipo_d       = 4'd0;
      result_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         S_LOAD: begin
            pipo_sel = 1'b1;
            pipo_d   = r_nibble;
         end
         S_RESP:  result_valid = 1'b1;
         default: ;
      endcase
   end

   // Down-counter starts at N and exits at 1, so N = max never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_nibble <= 4'd0;
         r_shamt  <= '0;
         r_cnt    <= '0;
         r_result <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_nibble <= in_nibble;
                  r_shamt  <= in_shamt;
               end
            end
            S_LOAD:    r_cnt    <= r_shamt;
            S_SHIFT:   r_cnt    <= r_cnt - SHAMT_W'(1);
            S_CAPTURE: r_result <= pipo_q;
            default: ;
         endcase
      end
   end

   assign result = r_result;

`ifdef PIPO_SHIFT_CTRL_CHECK_EN
   logic [7:0] w_expect;
   logic       r_err;

   assign w_expect = {4'b0000, r_nibble} << r_shamt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                        r_err <= 1'b0;
      else if (r_state == S_CAPTURE && pipo_q != w_expect) r_err <= 1'b1;
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipo_shift_ctrl.sv
// Directed bench for pipo_shift_ctrl with a behavioural pipo model closing the loop on pipo_q.
`timescale 1ns/1ps

module tb_pipo_shift_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_nibble;
   logic [2:0] in_shamt;
   logic [3:0] pipo_d;
   logic       pipo_sel;
   logic [7:0] pipo_q;
   logic       result_valid;
   logic       result_ready;
   logic [7:0] result;
   logic       busy;
   logic       err;

   logic [7:0] model_q;
   logic       ovr;
   int         n_checks = 0;
   int         n_fail   = 0;

`ifdef PIPO_SHIFT_CTRL_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   always #5 clk = ~clk;

   pipo_shift_ctrl #(.SHAMT_W(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_nibble    (in_nibble),
      .in_shamt     (in_shamt),
      .pipo_d       (pipo_d),
      .pipo_sel     (pipo_sel),
      .pipo_q       (pipo_q),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result),
      .busy         (busy),
      .err          (err)
   );

   // Pipo register: parallel load of the nibble into Q[3:0], else shift left by one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         model_q <= 8'd0;
      else if (pipo_sel) model_q <= {4'b0000, pipo_d};
      else               model_q <= {model_q[6:0], 1'b0};
   end

   assign pipo_q = ovr ? 8'hFF : model_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One full transaction; latency counts the accept edge as edge 1.
   task automatic run(input string tag, input logic [3:0] nib, input logic [2:0] n,
                      input int hold, input logic [7:0] exp);
      int   edges;
      int   lat;
      int   n_load;
      int   n_zero;
      logic bad_d;
      logic bad_rdy;
      logic bad_hold;
      edges = 1; lat = 0; n_load = 0; n_zero = 0;
      bad_d = 1'b0; bad_rdy = 1'b0; bad_hold = 1'b0;
      @(negedge clk);
      check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
      in_valid     = 1'b1;
      in_nibble    = nib;
      in_shamt     = n;
      result_ready = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      in_nibble = 4'd0;
      in_shamt  = 3'd0;
      for (int i = 0; i < 40; i++) begin
         if (result_valid) begin
            lat = edges;
            break;
         end
         if (pipo_sel) begin
            n_load++;
            if (pipo_d !== nib) bad_d = 1'b1;
         end else begin
            if (pipo_d !== 4'd0) bad_d = 1'b1;
            if (busy) n_zero++;
         end
         if (in_ready) bad_rdy = 1'b1;
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check({tag, ".latency"}, 32'(lat), 32'(n) + 32'd3);
      check({tag, ".load_cycles"}, 32'(n_load), 32'd1);
      check({tag, ".sel0_cycles"}, 32'(n_zero), 32'(n) + 32'd1);
      check({tag, ".pipo_d"}, 32'(bad_d), 32'd0);
      check({tag, ".ready_low"}, 32'(bad_rdy), 32'd0);
      check({tag, ".result"}, 32'(result), 32'(exp));
      if (hold > 0) begin
         in_valid  = 1'b1;
         in_nibble = 4'hF;
         in_shamt  = 3'd1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (result !== exp || !result_valid || in_ready || !busy) bad_hold = 1'b1;
         end
         check({tag, ".hold_stable"}, 32'(bad_hold), 32'd0);
         result_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      check({tag, ".valid_drop"}, 32'(result_valid), 32'd0);
      check({tag, ".back_idle"}, {30'd0, in_ready, busy}, 32'b10);
      in_valid  = 1'b0;
      in_nibble = 4'd0;
      in_shamt  = 3'd0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".outs"},
            {15'd0, in_ready, busy, result_valid, pipo_sel, pipo_d, err, result},
            {15'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0});
   endtask

   initial begin
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_nibble    = 4'd0;
      in_shamt     = 3'd0;
      result_ready = 1'b0;
      ovr          = 1'b0;
      #1;
      check_reset_vals("reset");
      #22;
      reset = 1'b0;

      run("n2",   4'b1011, 3'd2, 0, 8'b0010_1100);
      run("n0",   4'b1011, 3'd0, 0, 8'h0B);
      run("n7",   4'b1111, 3'd7, 0, 8'h80);
      run("n4",   4'b0110, 3'd4, 0, 8'h60);
      run("bp",   4'b1001, 3'd3, 6, 8'h48);

      // Abort in SHIFT after two shifts: accept edge, LOAD edge, then two SHIFT edges.
      @(negedge clk);
      in_valid  = 1'b1;
      in_nibble = 4'b0101;
      in_shamt  = 3'd5;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("abort.in_shift", {30'd0, busy, pipo_sel}, 32'b10);
      reset = 1'b1;
      #1;
      check_reset_vals("abort");
      @(negedge clk);
      reset = 1'b0;
      begin
         logic seen_valid;
         seen_valid = 1'b0;
         repeat (8) begin
            @(negedge clk);
            if (result_valid || busy) seen_valid = 1'b1;
         end
         check("abort.no_result", 32'(seen_valid), 32'd0);
      end
      run("post_abort", 4'b0001, 3'd1, 0, 8'h02);

      ovr = 1'b1;
      run("ovr", 4'b0001, 3'd1, 0, 8'hFF);
      ovr = 1'b0;
      check("err.after_ovr", 32'(err), 32'(EXP_ERR));
      run("good", 4'b0011, 3'd2, 0, 8'h0C);
      check("err.sticky", 32'(err), 32'(EXP_ERR));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("err.cleared", 32'(err), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
